// File: rtl/tdpr_pkg.sv
// ---------------------------------------------------------------------------
// tdpr_pkg
// Shared definitions for the true dual-port RAM burst port:
//   - state_e          : burst sequencer states
//   - ADDR_SIZE_DEF    : default RAM address width
//   - DATA_SIZE_DEF    : default RAM word width
//   - RD_BUF_DEPTH     : depth of the read return buffer
//   - rd_credit_ok()   : decides whether another RAM read may be issued
// ---------------------------------------------------------------------------
package tdpr_pkg;

  localparam int ADDR_SIZE_DEF = 8;
  localparam int DATA_SIZE_DEF = 8;
  localparam int RD_BUF_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // A new read may be issued when buffered + in-flight reads leave a free
  // slot, counting the slot that the current output handshake frees.
  function automatic logic rd_credit_ok(input logic [1:0] occ,
                                        input logic       inflight,
                                        input logic       pop);
    logic [2:0] used;
    logic [2:0] avail;
    used  = {1'b0, occ} + {2'b00, inflight};
    avail = 3'(RD_BUF_DEPTH) + {2'b00, pop};
    return (used < avail);
  endfunction

endpackage

// File: rtl/tdpr_rd_skid.sv
// ---------------------------------------------------------------------------
// tdpr_rd_skid
// Two-entry FIFO holding returned read words tagged with the burst-last flag.
// Absorbs the RAM's one-cycle read latency while the consumer stalls.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_push          : write one entry (RAM data of a read issued last cycle)
//   i_push_data     : word to store
//   i_push_last     : last-beat tag to store with the word
//   i_pop           : consumer takes the head entry (ignored when empty)
//   o_valid         : head entry present
//   o_data, o_last  : head entry contents
//   o_occ           : number of stored entries (0..2)
// ---------------------------------------------------------------------------
module tdpr_rd_skid
  import tdpr_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_push,
  input  logic [DATA_SIZE-1:0] i_push_data,
  input  logic                 i_push_last,
  input  logic                 i_pop,
  output logic                 o_valid,
  output logic [DATA_SIZE-1:0] o_data,
  output logic                 o_last,
  output logic [1:0]           o_occ
);

  logic [DATA_SIZE-1:0] r_data_0;
  logic [DATA_SIZE-1:0] r_data_1;
  logic                 r_last_0;
  logic                 r_last_1;
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_occ;
  logic                 w_pop;

  assign w_pop = i_pop & (r_occ != 2'd0);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_0 <= {DATA_SIZE{1'b0}};
      r_data_1 <= {DATA_SIZE{1'b0}};
      r_last_0 <= 1'b0;
      r_last_1 <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        if (r_wr_ptr) begin
          r_data_1 <= i_push_data;
          r_last_1 <= i_push_last;
        end else begin
          r_data_0 <= i_push_data;
          r_last_0 <= i_push_last;
        end
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_rd_ptr ? r_data_1 : r_data_0;
  assign o_last  = r_rd_ptr ? r_last_1 : r_last_0;
  assign o_occ   = r_occ;

endmodule

// File: rtl/tdpr_burst_port.sv
// ---------------------------------------------------------------------------
// tdpr_burst_port
// Burst initiator for one port of a true dual-port RAM. Accepts one command
// (read/write, start address, beats-1) and sequences consecutive RAM accesses.
// Write beats stream in on wr_*; read beats stream out on rd_* through a
// two-entry return buffer.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              : command handshake
//   cmd_write, cmd_addr, cmd_len     : command fields (len = beats-1)
//   wr_valid/wr_ready, wr_data       : write-data stream
//   rd_valid/rd_ready, rd_data,
//   rd_last                          : read-data stream, last beat flagged
//   busy, done                       : burst in progress / completion pulse
//   ram_en, ram_we, ram_addr,
//   ram_din, ram_dout                : RAM port (read data 1 cycle later)
// ---------------------------------------------------------------------------
module tdpr_burst_port
  import tdpr_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_SIZE-1:0] cmd_addr,
  input  logic [ADDR_SIZE-1:0] cmd_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DATA_SIZE-1:0] wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_last,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [DATA_SIZE-1:0] ram_din,
  input  logic [DATA_SIZE-1:0] ram_dout
);

  localparam logic [ADDR_SIZE-1:0] ADDR_ZERO = {ADDR_SIZE{1'b0}};
  localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

  state_e               r_state;
  state_e               w_state_nxt;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [ADDR_SIZE-1:0] w_addr_nxt;
  logic [ADDR_SIZE-1:0] r_cnt;
  logic [ADDR_SIZE-1:0] w_cnt_nxt;
  logic                 r_inflight;
  logic                 w_inflight_nxt;
  logic                 r_inflight_last;
  logic                 w_inflight_last_nxt;
  logic                 r_done;
  logic                 w_done_nxt;

  logic                 w_cmd_ready;
  logic                 w_wr_ready;
  logic                 w_ram_en;
  logic                 w_ram_we;
  logic                 w_issue;
  logic                 w_rd_pop;
  logic                 w_rd_valid;
  logic                 w_rd_last;
  logic [DATA_SIZE-1:0] w_rd_data;
  logic [1:0]           w_occ;

  assign w_rd_pop = w_rd_valid & rd_ready;

  // Return buffer; the word read last cycle is captured while r_inflight.
  tdpr_rd_skid #(
    .DATA_SIZE (DATA_SIZE)
  ) u_rd_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (ram_dout),
    .i_push_last (r_inflight_last),
    .i_pop       (w_rd_pop),
    .o_valid     (w_rd_valid),
    .o_data      (w_rd_data),
    .o_last      (w_rd_last),
    .o_occ       (w_occ)
  );

  // State, counters, in-flight tracking and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_addr          <= ADDR_ZERO;
      r_cnt           <= ADDR_ZERO;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_addr          <= w_addr_nxt;
      r_cnt           <= w_cnt_nxt;
      r_inflight      <= w_inflight_nxt;
      r_inflight_last <= w_inflight_last_nxt;
      r_done          <= w_done_nxt;
    end
  end

  // Next-state, counter updates and RAM/handshake strobes.
  always_comb begin
    w_state_nxt         = r_state;
    w_addr_nxt          = r_addr;
    w_cnt_nxt           = r_cnt;
    w_inflight_nxt      = 1'b0;
    w_inflight_last_nxt = 1'b0;
    w_done_nxt          = 1'b0;
    w_cmd_ready         = 1'b0;
    w_wr_ready          = 1'b0;
    w_ram_en            = 1'b0;
    w_ram_we            = 1'b0;
    w_issue             = 1'b0;

    case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_addr_nxt  = cmd_addr;
          w_cnt_nxt   = cmd_len;
          w_state_nxt = cmd_write ? WRITE : READ;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      WRITE: begin
        w_wr_ready = 1'b1;
        w_ram_en   = wr_valid;
        w_ram_we   = wr_valid;
        if (wr_valid) begin
          w_addr_nxt = r_addr + ADDR_ONE;
          // r_cnt holds beats-1, so zero means this is the final beat.
          if (r_cnt == ADDR_ZERO) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - ADDR_ONE;
          end
        end else begin
          w_state_nxt = WRITE;
        end
      end

      READ: begin
        w_issue  = rd_credit_ok(w_occ, r_inflight, w_rd_pop);
        w_ram_en = w_issue;
        if (w_issue) begin
          w_addr_nxt          = r_addr + ADDR_ONE;
          w_inflight_nxt      = 1'b1;
          w_inflight_last_nxt = (r_cnt == ADDR_ZERO);
          if (r_cnt == ADDR_ZERO) begin
            w_state_nxt = DRAIN;
          end else begin
            w_cnt_nxt = r_cnt - ADDR_ONE;
          end
        end else begin
          w_state_nxt = READ;
        end
      end

      DRAIN: begin
        if ((w_occ == 2'd0) && !r_inflight) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = DRAIN;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign cmd_ready = w_cmd_ready;
  assign wr_ready  = w_wr_ready;
  assign ram_en    = w_ram_en;
  assign ram_we    = w_ram_we;
  assign ram_addr  = r_addr;
  assign ram_din   = wr_data;
  assign rd_valid  = w_rd_valid;
  assign rd_data   = w_rd_data;
  assign rd_last   = w_rd_last;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_tdpr_burst_port.sv
// ---------------------------------------------------------------------------
// tb_tdpr_burst_port
// Self-checking bench for tdpr_burst_port. A simple synchronous RAM is
// attached to the RAM port; a separate reference memory is updated at the
// burst level and supplies the expected read streams.
// ---------------------------------------------------------------------------
module tb_tdpr_burst_port;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_len;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       busy;
  logic       done;
  logic       ram_en;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  logic [7:0] tb_ram  [256];
  logic [7:0] ref_mem [256];

  int n_checks = 0;
  int n_errors = 0;

  tdpr_burst_port #(
    .ADDR_SIZE (8),
    .DATA_SIZE (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy),
    .done      (done),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) tb_ram[ram_addr] <= ram_din;
      else        ram_dout <= tb_ram[ram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input bit wr, input logic [7:0] a, input logic [7:0] l);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    #1;
    check_eq("cmd_ready_idle", cmd_ready, 1);
    check_eq("busy_idle", busy, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_write = $urandom_range(0, 1);
    cmd_addr  = $urandom;
    cmd_len   = $urandom;
  endtask

  // Feed len+1 random beats, idle_pct percent of cycles with wr_valid low.
  task automatic run_write(input logic [7:0] a, input int l, input int idle_pct, output int cycles);
    logic [7:0] data[$];
    logic [7:0] ea;
    int i = 0;
    int cyc = 0;
    for (int k = 0; k <= l; k++) data.push_back(8'($urandom));
    while (i <= l && cyc < 3000) begin
      @(negedge clk);
      wr_valid = ($urandom_range(0, 99) >= idle_pct);
      wr_data  = data[i];
      rd_ready = $urandom_range(0, 1);
      #1;
      check_eq("wr_ready", wr_ready, 1);
      check_eq("wr_busy", busy, 1);
      check_eq("wr_cmd_ready", cmd_ready, 0);
      check_eq("wr_ram_en", ram_en, wr_valid);
      check_eq("wr_ram_we", ram_we, wr_valid);
      check_eq("wr_done_early", done, 0);
      if (wr_valid) begin
        ea = a + 8'(i);
        check_eq("wr_addr", ram_addr, ea);
        check_eq("wr_din", ram_din, data[i]);
        ref_mem[ea] = data[i];
        i++;
      end
      cyc++;
    end
    check_eq("wr_complete", i, l + 1);
    cycles = cyc;
  endtask

  // Collect len+1 beats; rd_ready low for the first stall0 cycles, then
  // low stall_pct percent of the time.
  task automatic run_read(input logic [7:0] a, input int l, input int stall_pct,
                          input int stall0, output int cycles, output int first_valid);
    logic [7:0] exp_q[$];
    logic [7:0] ea;
    int issued = 0;
    int recv = 0;
    int cyc = 0;
    first_valid = -1;
    for (int k = 0; k <= l; k++) begin
      ea = a + 8'(k);
      exp_q.push_back(ref_mem[ea]);
    end
    while (recv <= l && cyc < 4000) begin
      @(negedge clk);
      rd_ready = (cyc < stall0) ? 1'b0 : ($urandom_range(0, 99) >= stall_pct);
      wr_valid = $urandom_range(0, 1);
      #1;
      check_eq("rd_ram_we", ram_we, 0);
      check_eq("rd_wr_ready", wr_ready, 0);
      check_eq("rd_busy", busy, 1);
      check_eq("rd_cmd_ready", cmd_ready, 0);
      check_eq("rd_done_early", done, 0);
      if (ram_en) begin
        ea = a + 8'(issued);
        check_eq("rd_addr", ram_addr, ea);
        issued++;
      end
      if (rd_valid && first_valid < 0) first_valid = cyc;
      if (rd_valid && rd_ready) begin
        check_eq("rd_data", rd_data, exp_q[recv]);
        check_eq("rd_last", rd_last, (recv == l));
        recv++;
      end
      check_eq("rd_outstanding_le2", (issued - recv) <= 2, 1);
      check_eq("rd_no_overissue", issued <= l + 1, 1);
      if (stall0 >= 3 && l >= 1 && cyc == stall0 - 1)
        check_eq("rd_stalled_issues", issued, 2);
      cyc++;
    end
    check_eq("rd_complete", recv, l + 1);
    cycles = cyc;
  endtask

  // Expect a single done pulse within max_wait extra cycles, in IDLE.
  task automatic finish_check(input int max_wait);
    bit seen = 1'b0;
    for (int w = 0; w <= max_wait && !seen; w++) begin
      @(negedge clk);
      wr_valid = 1'b0;
      #1;
      if (done) seen = 1'b1;
    end
    check_eq("done_pulse", seen, 1);
    check_eq("done_busy", busy, 0);
    check_eq("done_cmd_ready", cmd_ready, 1);
    check_eq("done_ram_en", ram_en, 0);
    @(posedge clk);
    #1;
    check_eq("done_one_shot", done, 0);
  endtask

  initial begin
    int cyc;
    int fv;
    int issued;
    bit wr;
    logic [7:0] a;
    int l;
    int pct;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 8'h00;
    cmd_len   = 8'h00;
    wr_valid  = 1'b0;
    wr_data   = 8'h00;
    rd_ready  = 1'b0;
    #3;
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ram_en", ram_en, 0);
    check_eq("rst_ram_we", ram_we, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_rd_last", rd_last, 0);
    check_eq("rst_wr_ready", wr_ready, 0);
    check_eq("rst_ram_addr", ram_addr, 0);
    check_eq("rst_rd_data", rd_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-length write fills the whole RAM, wrapping to end at 0x7F.
    start_cmd(1'b1, 8'h80, 8'hFF);
    run_write(8'h80, 255, 0, cyc);
    check_eq("full_wr_cycles", cyc, 256);
    finish_check(0);

    // Write 0x10, 4 beats, no stalls.
    start_cmd(1'b1, 8'h10, 8'd3);
    run_write(8'h10, 3, 0, cyc);
    check_eq("wr4_cycles", cyc, 4);
    finish_check(0);

    // Read back with rd_ready high: first beat 2 cycles after accept.
    start_cmd(1'b0, 8'h10, 8'd3);
    run_read(8'h10, 3, 0, 0, cyc, fv);
    check_eq("rd4_first_valid", fv, 2);
    check_eq("rd4_cycles", cyc, 6);
    finish_check(2);

    // Same read, consumer stalled for 5 cycles.
    start_cmd(1'b0, 8'h10, 8'd3);
    run_read(8'h10, 3, 0, 5, cyc, fv);
    finish_check(2);

    // Address wrap FE, FF, 00, 01.
    start_cmd(1'b1, 8'hFE, 8'd3);
    run_write(8'hFE, 3, 0, cyc);
    finish_check(0);

    // Command held during a write burst is accepted in the done cycle.
    start_cmd(1'b1, 8'h20, 8'd2);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h20;
    cmd_len   = 8'd2;
    run_write(8'h20, 2, 0, cyc);
    finish_check(0);
    cmd_valid = 1'b0;
    run_read(8'h20, 2, 0, 0, cyc, fv);
    check_eq("b2b_first_valid", fv, 2);
    finish_check(2);

    // Reset in the middle of a read burst with the buffer full.
    start_cmd(1'b0, 8'h10, 8'd3);
    issued = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rd_ready = 1'b0;
      #1;
      if (ram_en) issued++;
    end
    check_eq("rst_burst_issued", issued, 2);
    check_eq("rst_burst_rd_valid", rd_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_ram_en", ram_en, 0);
    check_eq("midrst_rd_valid", rd_valid, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_cmd_ready", cmd_ready, 1);
    check_eq("midrst_ram_addr", ram_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_cmd(1'b0, 8'h13, 8'd0);
    run_read(8'h13, 0, 0, 0, cyc, fv);
    finish_check(2);

    // Randomised bursts against the reference memory.
    for (int k = 0; k < 30; k++) begin
      wr  = $urandom_range(0, 1);
      a   = $urandom;
      l   = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 15);
      pct = $urandom_range(0, 50);
      start_cmd(wr, a, 8'(l));
      if (wr) begin
        run_write(a, l, pct, cyc);
        finish_check(0);
      end else begin
        run_read(a, l, pct, $urandom_range(0, 6), cyc, fv);
        finish_check(2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tdpr_burst_port.md
# tdpr_burst_port

Burst initiator for one port of the true dual-port RAM. It accepts a single command (read or write, start address, beat count) and sequences consecutive RAM accesses. Write data arrives as a valid/ready stream; read data leaves as a valid/ready stream with a 2-entry return buffer that absorbs the RAM's 1-cycle read latency under backpressure. Two instances, one per RAM port, give client logic a streaming view of the shared memory.

## Interface
- ADDR_SIZE, 8, RAM address width; addresses wrap modulo 2^ADDR_SIZE
- DATA_SIZE, 8, RAM word width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_SIZE  start address
- cmd_len  in  ADDR_SIZE  beats minus one (0 → 1 beat, all-ones → 2^ADDR_SIZE beats)
- wr_valid / wr_ready  in / out  1  write-data handshake
- wr_data  in  DATA_SIZE  write beat
- rd_valid / rd_ready  out / in  1  read-data handshake
- rd_data  out  DATA_SIZE  read beat
- rd_last  out  1  marks the final read beat of the burst
- busy  out  1  a burst is in progress (state ≠ IDLE)
- done  out  1  one-cycle pulse on burst completion
- ram_en, ram_we  out  1  RAM port enable / write enable
- ram_addr  out  ADDR_SIZE  RAM port address
- ram_din  out  DATA_SIZE  RAM write data
- ram_dout  in  DATA_SIZE  RAM read data, valid the cycle after an enabled read

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready=1. On handshake, latch addr into addr counter and len into beat counter; go to WRITE or READ.
- WRITE: wr_ready=1. ram_en=ram_we=wr_valid, ram_addr=counter, ram_din=wr_data (combinational pass-through). Each accepted beat increments the address (wraps) and decrements the count. When the last beat is accepted → IDLE with done.
- READ: issue a read (ram_en=1, ram_we=0) only when credit > 0, where credit = 2 − buffer occupancy − in-flight reads + (rd_valid & rd_ready). ram_dout is captured into the buffer the cycle after issue. After the last issue → DRAIN.
- DRAIN: wait until the buffer is empty and nothing is in flight → IDLE with done.
- The buffer is a 2-entry FIFO in issue order. rd_last is tagged on the entry from the final issued beat.
- Outside WRITE: wr_ready=0 and ram_we=0. Outside READ/WRITE: ram_en=0.
- Reset (async, any time): state→IDLE, counters→0, buffer emptied, in-flight cleared. Outputs during reset: ram_en=ram_we=0, rd_valid=0, rd_last=0, wr_ready=0, busy=0, done=0, cmd_ready=1, ram_addr=0, rd_data=0.

## Timing
- Command accepted at edge E0. In WRITE, the first RAM write can be sampled at E1.
- Read: first ram_en is high in cycle E0→E1 (RAM samples at E1). rd_valid is first high after E2, i.e. 2-cycle latency from accept to first read beat.
- Sustained throughput is 1 beat/cycle for both directions when the stream partner never stalls.
- With rd_ready low, at most 2 reads are outstanding (buffered plus in flight). No read is lost or reordered.
- done asserts in the first IDLE cycle after the burst. cmd_ready is also 1 in that cycle, so back-to-back commands incur one idle cycle.
- cmd_valid while busy is ignored (cmd_ready=0). Command fields are sampled only at the handshake.
- Full-length bursts (cmd_len all-ones) visit every address exactly once, ending at start−1.

## Structure
- Shared package tdpr_pkg: state enum {IDLE, WRITE, READ, DRAIN} and default ADDR_SIZE/DATA_SIZE constants.
- Sub-module tdpr_rd_skid: 2-entry FIFO carrying {rd_last, data}, exposing occupancy for the credit computation.
- Top: FSM, address/beat counters, in-flight flag, credit logic.

## Test plan
- Write addr 0x10, len 3, data A0..A3, wr_valid held high → ram_en=ram_we=1 for 4 cycles at 0x10..0x13; done pulses once; busy falls.
- Read addr 0x10, len 3, rd_ready=1 → rd_valid first high 2 cycles after accept; A0..A3 on consecutive cycles; rd_last only with A3.
- Same read with rd_ready low for 5 cycles after accept → only 2 ram_en pulses issued; then rd_ready=1 yields A0..A3 in order, no duplicates.
- Write addr 0xFE, len 3 → ram_addr sequence FE, FF, 00, 01.
- cmd_valid held high during a burst → cmd_ready=0 until the done cycle; second command accepted in that cycle.
- Assert rst_n=0 mid read burst with the buffer full → ram_en and rd_valid drop immediately, busy=0; after release, a 1-beat read of 0x13 returns A3.
